// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: level count, the
// generate/propagate pair type, and where the pipeline registers sit.
package cla_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // One p/g generation level followed by the Kogge-Stone prefix levels.
  function automatic int unsigned levels(input int unsigned width);
    return clog2(width) + 1;
  endfunction

  // Index of the level that register k follows: ceil((k+1)*LEVELS/STAGES)-1.
  function automatic int unsigned stage_level(input int unsigned k, input int unsigned lv,
                                              input int unsigned st);
    return ((k + 1) * lv + st - 1) / st - 1;
  endfunction

  // Register index that follows the given level, or -1 when the level is not a boundary.
  function automatic int boundary_stage(input int unsigned level, input int unsigned lv,
                                        input int unsigned st);
    for (int unsigned k = 0; k < st; k++) begin
      if (stage_level(k, lv, st) == level) return int'(k);
    end
    return -1;
  endfunction

endpackage

// File: rtl/cla_prefix_cell.sv
// Kogge-Stone black cell: merges a high group with the adjacent low group.
module cla_prefix_cell
  import cla_pkg::*;
(
  input  gp_t hi_i,
  input  gp_t lo_i,
  output gp_t out_o
);

  assign out_o.g = hi_i.g | (hi_i.p & lo_i.g);
  assign out_o.p = hi_i.p & lo_i.p;

endmodule

// File: rtl/cla_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready on both sides and collapsing bubbles.
// Define CLA_PIPE_SUB_EN to add the 'sub' port (a - b via ~b and forced carry-in).
module cla_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LEVELS = levels(WIDTH);
  localparam int unsigned LAST   = STAGES - 1;

  // Per-level combinational view: raw p, group G, group P, carry-in.
  logic [WIDTH-1:0] lv_p  [LEVELS];
  logic [WIDTH-1:0] lv_g  [LEVELS];
  logic [WIDTH-1:0] lv_pp [LEVELS];
  logic             lv_c  [LEVELS];

  logic [WIDTH-1:0] p_q   [STAGES];
  logic [WIDTH-1:0] g_q   [STAGES];
  logic [WIDTH-1:0] pp_q  [STAGES];
  logic             c_q   [STAGES];
  logic [STAGES-1:0] valid_q, valid_d, ld;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef CLA_PIPE_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Level 0: carry-in folded into bit 0 as a generate from bit -1.
  assign lv_p[0]  = a ^ b_eff;
  assign lv_g[0]  = (a & b_eff) | {{(WIDTH-1){1'b0}}, (a[0] ^ b_eff[0]) & cin_eff};
  assign lv_pp[0] = {lv_p[0][WIDTH-1:1], 1'b0};
  assign lv_c[0]  = cin_eff;

  for (genvar l = 1; l < int'(LEVELS); l++) begin : g_lvl
    localparam int BS = boundary_stage(l - 1, LEVELS, STAGES);
    localparam int D  = 1 << (l - 1);
    logic [WIDTH-1:0] p_in, g_in, pp_in, g_o, pp_o;
    logic             c_in;

    if (BS >= 0) begin : g_from_reg
      assign p_in  = p_q[BS];
      assign g_in  = g_q[BS];
      assign pp_in = pp_q[BS];
      assign c_in  = c_q[BS];
    end else begin : g_from_comb
      assign p_in  = lv_p[l-1];
      assign g_in  = lv_g[l-1];
      assign pp_in = lv_pp[l-1];
      assign c_in  = lv_c[l-1];
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      if (i >= D) begin : g_cell
        gp_t hi, lo, res;
        assign hi = gp_t'({g_in[i], pp_in[i]});
        assign lo = gp_t'({g_in[i-D], pp_in[i-D]});
        cla_prefix_cell u_cell (
          .hi_i  (hi),
          .lo_i  (lo),
          .out_o (res)
        );
        assign g_o[i]  = res.g;
        assign pp_o[i] = res.p;
      end else begin : g_pass
        assign g_o[i]  = g_in[i];
        assign pp_o[i] = pp_in[i];
      end
    end

    assign lv_p[l]  = p_in;
    assign lv_g[l]  = g_o;
    assign lv_pp[l] = pp_o;
    assign lv_c[l]  = c_in;
  end

  // Stall chain: a stage loads when empty or when its consumer drains it this cycle.
  always_comb begin
    logic take;
    ld   = '0;
    take = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      ld[k] = ~valid_q[k] | take;
      take  = ld[k];
    end
    valid_d = (ld & STAGES'({valid_q, in_valid})) | (~ld & valid_q);
  end

  assign in_ready = ld[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stg
    localparam int unsigned LK = stage_level(k, LEVELS, STAGES);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_q[k]  <= '0;
        g_q[k]  <= '0;
        pp_q[k] <= '0;
        c_q[k]  <= 1'b0;
      end else if (ld[k]) begin
        p_q[k]  <= lv_p[LK];
        g_q[k]  <= lv_g[LK];
        pp_q[k] <= lv_pp[LK];
        c_q[k]  <= lv_c[LK];
      end
    end
  end

  // Carry into bit i is G of bit i-1; carry into bit 0 is the carry-in itself.
  logic [WIDTH-1:0] carry_in;
  assign carry_in  = {g_q[LAST][WIDTH-2:0], c_q[LAST]};
  assign out_valid = valid_q[LAST];
  assign sum       = out_valid ? (p_q[LAST] ^ carry_in) : '0;
  assign cout      = out_valid & g_q[LAST][WIDTH-1];
  assign ovf       = out_valid & (g_q[LAST][WIDTH-1] ^ carry_in[WIDTH-1]);

endmodule

// File: tb/tb_cla_pipe.sv
// Bench for cla_pipe: arithmetic reference model with an in-order queue,
// directed literal vectors, back-to-back, backpressure, random stalls and mid-run reset.
module tb_cla_pipe;

  localparam int unsigned W      = 16;
  localparam int unsigned STAGES = 3;

  logic         clk, rst_n, in_valid, in_ready, cin, sub;
  logic [W-1:0] a, b, sum;
  logic         out_valid, out_ready, cout, ovf;

  cla_pipe #(.WIDTH(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_PIPE_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W+1:0] exp;
    int           cyc;
  } item_t;

  item_t q[$];
  int checks = 0, failures = 0;
  int cyc = 0, pops = 0, run = 0, max_run = 0;
  bit lat_en = 0;
  bit prev_stall = 0;
  logic [W+1:0] prev_res;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition, overflow from the sign-extended sum.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    logic [W-1:0] be;
    logic         ce;
    logic [W:0]   u, s;
    be = ms ? ~mb : mb;
    ce = ms ? 1'b1 : mc;
    u  = {1'b0, ma} + {1'b0, be} + (W+1)'(ce);
    s  = {ma[W-1], ma} + {be[W-1], be} + (W+1)'(ce);
    return {s[W] ^ s[W-1], u[W], u[W-1:0]};
  endfunction

  always @(posedge clk) cyc++;

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    logic [W+1:0] res;
    item_t it;
    res = {ovf, cout, sum};
    if (!rst_n) begin
      q.delete();
      prev_stall = 0;
      run = 0;
      chk(out_valid == 1'b0 && res == '0, "reset_outputs", 64'(res), 64'(0));
    end else begin
      if (prev_stall)
        chk(out_valid && res == prev_res, "hold_stable", 64'(res), 64'(prev_res));
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_out", 64'(res), 64'(0));
        end else begin
          it = q[0];
          chk(res == it.exp, "result", 64'(res), 64'(it.exp));
          if (out_ready) begin
            void'(q.pop_front());
            pops++;
            if (lat_en) chk(cyc - it.cyc == int'(STAGES), "latency", 64'(cyc - it.cyc), 64'(STAGES));
          end
        end
      end else begin
        run = 0;
        chk(res == '0, "idle_gated", 64'(res), 64'(0));
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = res;
      if (in_valid && in_ready) begin
        it.exp = model(a, b, cin, sub);
        it.cyc = cyc;
        q.push_back(it);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc, input logic ts);
    bit acc;
    acc = 0;
    a = ta; b = tb2; cin = tc; sub = ts;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk(1'b0, "send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic directed(input logic [W-1:0] da, input logic [W-1:0] db, input logic dc,
                          input logic ds, input logic [W-1:0] es, input logic ec,
                          input logic eo, input string nm);
    int lat;
    bit found;
    send(da, db, dc, ds);
    lat = 1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk(found, {nm, "_seen"}, 64'(found), 64'(1));
    chk(lat == int'(STAGES), {nm, "_latency"}, 64'(lat), 64'(STAGES));
    chk(sum == es, {nm, "_sum"}, 64'(sum), 64'(es));
    chk(cout == ec && ovf == eo, {nm, "_cout_ovf"}, 64'({cout, ovf}), 64'({ec, eo}));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = (q.size() == 0) && !out_valid;
      @(posedge clk);
      #1;
    end
    chk(done, {nm, "_drain"}, 64'(q.size()), 64'(0));
  endtask

  function automatic logic rsub();
`ifdef CLA_PIPE_SUB_EN
    return 1'($urandom);
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    int p0, nacc, sent, nstale;
    bit acc;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #23 rst_n = 1'b1;
    @(negedge clk);
    chk(in_ready == 1'b1, "ready_after_reset", 64'(in_ready), 64'(1));
    chk(out_valid == 1'b0, "valid_after_reset", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;

    lat_en = 1;
    directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
    directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
    directed(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "cin");
    directed(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");
`ifdef CLA_PIPE_SUB_EN
    directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub");
`endif

    p0 = pops;
    max_run = 0;
    for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 1'($urandom), rsub());
    drain("b2b");
    chk(pops - p0 == 8, "b2b_count", 64'(pops - p0), 64'(8));
    chk(max_run >= 8, "b2b_consecutive", 64'(max_run), 64'(8));

    lat_en = 0;
    out_ready = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = rsub();
    in_valid = 1'b1;
    nacc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        nacc++;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = rsub();
      end
    end
    chk(nacc == int'(STAGES), "bp_accepts", 64'(nacc), 64'(STAGES));
    @(negedge clk);
    chk(in_ready == 1'b0, "bp_full_ready", 64'(in_ready), 64'(0));
    chk(out_valid == 1'b1, "bp_full_valid", 64'(out_valid), 64'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk(in_ready == 1'b1, "bp_same_cycle_push", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain("bp");

    sent = 0;
    acc = 0;
    for (int c = 0; c < 4000 && sent < 400; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom % 3) != 0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = rsub();
      end
      out_ready = ($urandom % 4) != 0;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk(sent == 400, "rand_sent", 64'(sent), 64'(400));
    drain("rand");

    lat_en = 1;
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'($urandom), rsub());
    #2 rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "rst_async_valid", 64'(out_valid), 64'(0));
    chk(sum == '0, "rst_async_sum", 64'(sum), 64'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    nstale = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) nstale++;
    end
    chk(nstale == 0, "rst_no_stale", 64'(nstale), 64'(0));
    @(posedge clk);
    #1;
    directed(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
